// File: rtl/vt52_pkg.sv
// Shared types and constants for the VT52 host-transmit path.
package vt52_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLOW = 2'd1,
        RESP = 2'd2,
        KBD  = 2'd3
    } tx_arb_state_t;

    localparam logic [7:0] ASCII_ESC  = 8'h1B;
    localparam logic [7:0] ASCII_XON  = 8'h11;
    localparam logic [7:0] ASCII_XOFF = 8'h13;

    // Identify reply: ESC / K
    localparam int IDENT_LEN = 3;
    localparam logic [7:0] IDENT_SEQ [IDENT_LEN] = '{ASCII_ESC, 8'h2F, 8'h4B};

    function automatic logic [7:0] ident_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return IDENT_SEQ[0];
            2'd1:    return IDENT_SEQ[1];
            default: return IDENT_SEQ[2];
        endcase
    endfunction

endpackage

// File: rtl/vt52_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module vt52_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_en;
    logic             push_en;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_en  = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign push_en = push && (!full || pop_en);
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/vt52_tx_arbiter.sv
// Arbitrates flow-control, identify-reply and keyboard bytes onto the UART TX.
// XON/XOFF generation is built only when VT52_XONXOFF_EN is defined.
module vt52_tx_arbiter
    import vt52_pkg::*;
#(
    parameter int KBD_FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    input  logic       resp_req,
    input  logic       rx_almost_full,
    input  logic       ovf_clr,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       resp_busy,
    output logic       kbd_overflow,
    output logic       xoff_active
);

    localparam logic [1:0] LAST_IDX = 2'(IDENT_LEN - 1);

    tx_arb_state_t state_reg, state_next;
    logic [7:0]    tx_data_reg, tx_data_next;
    logic          tx_valid_reg, tx_valid_next;
    logic [1:0]    idx_reg, idx_next;
    logic          pend_reg, pend_next;
    logic          busy_reg, busy_next;
    logic          xoff_reg, xoff_next;
    logic          flow_ret_reg, flow_ret_next;
    logic          ovf_reg, ovf_next;

    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       xfer;
    logic       flow_need;
    logic [7:0] flow_byte;

    vt52_sync_fifo #(
        .WIDTH (8),
        .DEPTH (KBD_FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (kbd_valid),
        .din     (kbd_data),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

`ifdef VT52_XONXOFF_EN
    assign flow_need = rx_almost_full ^ xoff_reg;
`else
    logic unused_rx_almost_full;
    assign unused_rx_almost_full = rx_almost_full;
    assign flow_need = 1'b0;
`endif

    assign xfer      = tx_valid_reg && tx_ready;
    assign flow_byte = xoff_reg ? ASCII_XON : ASCII_XOFF;

    always_comb begin
        state_next    = state_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        idx_next      = idx_reg;
        pend_next     = pend_reg;
        busy_next     = busy_reg;
        xoff_next     = xoff_reg;
        flow_ret_next = flow_ret_reg;
        fifo_pop      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (flow_need) begin
                    state_next    = FLOW;
                    tx_data_next  = flow_byte;
                    tx_valid_next = 1'b1;
                    flow_ret_next = 1'b0;
                end else if (pend_reg) begin
                    state_next    = RESP;
                    tx_data_next  = ident_byte(2'd0);
                    tx_valid_next = 1'b1;
                    idx_next      = 2'd0;
                    pend_next     = 1'b0;
                end else if (!fifo_empty) begin
                    state_next    = KBD;
                    tx_data_next  = fifo_dout;
                    tx_valid_next = 1'b1;
                    fifo_pop      = 1'b1;
                end
            end
            FLOW: begin
                if (xfer) begin
                    xoff_next = !xoff_reg;
                    // A flow byte taken mid-reply resumes the reply without a bubble.
                    if (flow_ret_reg) begin
                        state_next   = RESP;
                        idx_next     = idx_reg + 2'd1;
                        tx_data_next = ident_byte(idx_reg + 2'd1);
                    end else begin
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
                    end
                end
            end
            RESP: begin
                if (xfer) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
                        busy_next     = 1'b0;
                    end else if (flow_need) begin
                        state_next    = FLOW;
                        tx_data_next  = flow_byte;
                        flow_ret_next = 1'b1;
                    end else begin
                        idx_next     = idx_reg + 2'd1;
                        tx_data_next = ident_byte(idx_reg + 2'd1);
                    end
                end
            end
            KBD: begin
                if (xfer) begin
                    state_next    = IDLE;
                    tx_valid_next = 1'b0;
                end
            end
            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
            end
        endcase

        if (resp_req && !busy_reg) begin
            pend_next = 1'b1;
            busy_next = 1'b1;
        end

        if (kbd_valid && fifo_full && !fifo_pop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            idx_reg      <= 2'd0;
            pend_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            xoff_reg     <= 1'b0;
            flow_ret_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            idx_reg      <= idx_next;
            pend_reg     <= pend_next;
            busy_reg     <= busy_next;
            xoff_reg     <= xoff_next;
            flow_ret_reg <= flow_ret_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign tx_data      = tx_data_reg;
    assign tx_valid     = tx_valid_reg;
    assign resp_busy    = busy_reg;
    assign kbd_overflow = ovf_reg;
    assign xoff_active  = xoff_reg;

endmodule

// File: tb/tb_vt52_tx_arbiter.sv
// Scoreboard bench for vt52_tx_arbiter; define VT52_XONXOFF_EN to exercise flow control.
module tb_vt52_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       resp_req;
    logic       rx_almost_full;
    logic       ovf_clr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       resp_busy;
    logic       kbd_overflow;
    logic       xoff_active;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    vt52_tx_arbiter #(.KBD_FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .kbd_data       (kbd_data),
        .kbd_valid      (kbd_valid),
        .resp_req       (resp_req),
        .rx_almost_full (rx_almost_full),
        .ovf_clr        (ovf_clr),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .resp_busy      (resp_busy),
        .kbd_overflow   (kbd_overflow),
        .xoff_active    (xoff_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic kbd(input logic [7:0] b);
        kbd_data  = b;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL %s_drain_timeout: got %0d bytes left, expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and checks hold-stability.
    initial begin
        logic       prev_valid;
        logic       prev_xfer;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
                prev_xfer  = 1'b0;
            end else begin
                if (prev_valid && !prev_xfer) begin
                    vectors++;
                    if (!tx_valid || tx_data !== prev_data) begin
                        miscompares++;
                        $display("FAIL hold_stable: got valid=%b data=%h, expected valid=1 data=%h",
                                 tx_valid, tx_data, prev_data);
                    end
                end
                if (tx_valid && tx_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_xfer: got %h, expected no transfer", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            miscompares++;
                            $display("FAIL xfer_byte: got %h, expected %h", tx_data, e);
                        end else begin
                            $display("xfer %h ok", tx_data);
                        end
                    end
                end
                prev_valid = tx_valid;
                prev_xfer  = tx_valid && tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        kbd_data       = 8'h00;
        kbd_valid      = 1'b0;
        resp_req       = 1'b0;
        rx_almost_full = 1'b0;
        ovf_clr        = 1'b0;
        tx_ready       = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
        check("rst_resp_busy", {7'd0, resp_busy}, 8'd0);
        check("rst_kbd_overflow", {7'd0, kbd_overflow}, 8'd0);
        check("rst_xoff_active", {7'd0, xoff_active}, 8'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Keyboard drain: latency and one bubble between bytes
        tx_ready = 1'b1;
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        kbd_data = 8'h41; kbd_valid = 1'b1; tick();
        check("kbd_lat_e0_valid", {7'd0, tx_valid}, 8'd0);
        kbd_data = 8'h42; tick();
        check("kbd_lat_e1_valid", {7'd0, tx_valid}, 8'd1);
        check("kbd_lat_e1_data", tx_data, 8'h41);
        kbd_data = 8'h43; tick();
        check("kbd_bubble_valid", {7'd0, tx_valid}, 8'd0);
        kbd_valid = 1'b0; tick();
        check("kbd_second_data", tx_data, 8'h42);
        drain("kbd");

        // Backpressure
        tx_ready = 1'b0;
        exp_q.push_back(8'h41);
        kbd(8'h41);
        tick();
        check("bp_valid", {7'd0, tx_valid}, 8'd1);
        repeat (20) tick();
        check("bp_data_held", tx_data, 8'h41);
        tx_ready = 1'b1;
        tick();
        check("bp_after_xfer_valid", {7'd0, tx_valid}, 8'd0);
        repeat (5) tick();
        check("bp_single_xfer", 8'(exp_q.size()), 8'd0);

        // Reply atomicity against queued keyboard bytes
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) kbd(8'h50 + 8'(i));
        tick();
        check("atom_inflight", tx_data, 8'h50);
        resp_req = 1'b1; tick(); resp_req = 1'b0;
        check("atom_busy_set", {7'd0, resp_busy}, 8'd1);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h2F); exp_q.push_back(8'h4B);
        for (int i = 1; i < 6; i++) exp_q.push_back(8'h50 + 8'(i));
        tx_ready = 1'b1;
        tick();
        check("atom_idle_after_kbd", {7'd0, tx_valid}, 8'd0);
        tick();
        check("atom_esc", tx_data, 8'h1B);
        tick();
        check("atom_slash_b2b", {tx_valid, tx_data[6:0]}, {1'b1, 7'h2F});
        tick();
        check("atom_k_b2b", {tx_valid, tx_data[6:0]}, {1'b1, 7'h4B});
        check("atom_busy_mid", {7'd0, resp_busy}, 8'd1);
        tick();
        check("atom_busy_clear", {7'd0, resp_busy}, 8'd0);
        drain("atom");

        // Overflow with one byte already held by the arbiter
        tx_ready = 1'b0;
        kbd(8'h5F);
        for (int i = 0; i < 8; i++) kbd(8'h60 + 8'(i));
        check("ovf_not_yet", {7'd0, kbd_overflow}, 8'd0);
        kbd(8'h68);
        check("ovf_set", {7'd0, kbd_overflow}, 8'd1);
        ovf_clr = 1'b1; kbd(8'h69); ovf_clr = 1'b0;
        check("ovf_set_wins_clr", {7'd0, kbd_overflow}, 8'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr", {7'd0, kbd_overflow}, 8'd0);
        exp_q.push_back(8'h5F);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h60 + 8'(i));
        exp_q.push_back(8'h6A);
        tx_ready = 1'b1;
        tick();
        kbd(8'h6A);
        check("ovf_full_push_pop", {7'd0, kbd_overflow}, 8'd0);
        drain("ovf");

`ifdef VT52_XONXOFF_EN
        // Flow control mid-reply
        exp_q.push_back(8'h1B); exp_q.push_back(8'h13);
        exp_q.push_back(8'h2F); exp_q.push_back(8'h4B);
        resp_req = 1'b1; tick(); resp_req = 1'b0;
        tick();
        rx_almost_full = 1'b1;
        drain("xoff");
        check("xoff_active_set", {7'd0, xoff_active}, 8'd1);
        exp_q.push_back(8'h11);
        rx_almost_full = 1'b0;
        tick();
        drain("xon");
        check("xoff_active_clr", {7'd0, xoff_active}, 8'd0);
`else
        // rx_almost_full has no effect without flow control
        rx_almost_full = 1'b1;
        exp_q.push_back(8'h33);
        kbd(8'h33);
        drain("noflow");
        check("noflow_xoff", {7'd0, xoff_active}, 8'd0);
        rx_almost_full = 1'b0;
`endif

        // Asynchronous reset mid-reply
        tx_ready = 1'b0;
        resp_req = 1'b1; tick(); resp_req = 1'b0;
        kbd(8'h70);
        check("arst_pre_valid", {7'd0, tx_valid}, 8'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tx_valid", {7'd0, tx_valid}, 8'd0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_resp_busy", {7'd0, resp_busy}, 8'd0);
        check("arst_overflow", {7'd0, kbd_overflow}, 8'd0);
        exp_q.delete();
        tick();
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        repeat (20) tick();
        check("arst_no_residual", {7'd0, tx_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
